bnn_inference_sequencer: RTL and testbench

- Top-level controller for the BNN inference pipeline.
- Accepts a start request and streams the binarised input image in, one pixel per handshake.
- Drives the shared 3-bit layer-state bus that enables layer 1, layer 2 and the final classifier layer in turn, and clears their sticky done flags.
- Captures the classifier answer and offers it on a valid/ready result handshake.

---
 rtl/bnn_inference_sequencer.sv | 141 ++++++++++++++
 tb/tb_bnn_inference_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_inference_sequencer.sv
// Top-level sequencer for the BNN pipeline: pixel load, layer stepping, result handshake.
// Optional per-layer watchdog compiled in with `define BNN_SEQ_WATCHDOG_EN.
module bnn_inference_sequencer #(
  parameter int unsigned NUM_PIXELS     = 784,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       pixel_valid_i,
  input  logic       pixel_in_i,
  output logic       pixel_ready_o,
  output logic [9:0] pixel_index_o,
  output logic       pixel_we_o,
  output logic       layer_clear_n_o,
  output logic [2:0] state_o,
  input  logic       layer_1_done_i,
  input  logic       layer_2_done_i,
  input  logic       layer_3_done_i,
  input  logic [3:0] answer_in_i,
  output logic [3:0] answer_o,
  output logic       result_valid_o,
  input  logic       result_ready_i,
  output logic       busy_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LOAD    = 3'b001,
    S_LAYER_1 = 3'b010,
    S_LAYER_2 = 3'b011,
    S_LAYER_3 = 3'b100,
    S_DONE    = 3'b101,
    S_ERROR   = 3'b111
  } state_e;

  localparam logic [9:0] LAST_PIX = 10'(NUM_PIXELS - 1);

  state_e     state_q, state_d;
  logic [9:0] pixel_index_q, pixel_index_d;
  logic       clear_n_q, clear_n_d;
  logic [3:0] answer_q, answer_d;
  logic       result_valid_q, result_valid_d;
  logic       error_q, error_d;
  logic       timeout;
  logic       last_beat;

  // The pixel bit goes straight to the image buffer; nothing here consumes it.
  logic unused_pixel_in;
  assign unused_pixel_in = pixel_in_i;

  assign last_beat = pixel_valid_i && (pixel_index_q == LAST_PIX);

`ifdef BNN_SEQ_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        in_layer;

  assign in_layer = (state_q == S_LAYER_1) || (state_q == S_LAYER_2) || (state_q == S_LAYER_3);
  assign timeout  = in_layer && (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = 16'd0;
    if (state_d == state_q && in_layer) wdog_d = wdog_q + 16'd1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) wdog_q <= 16'd0;
    else            wdog_q <= wdog_d;
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= S_IDLE;
      pixel_index_q  <= 10'd0;
      clear_n_q      <= 1'b1;
      answer_q       <= 4'd0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pixel_index_q  <= pixel_index_d;
      clear_n_q      <= clear_n_d;
      answer_q       <= answer_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  // Done beats timeout: the done check is evaluated first in each layer state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_LOAD;
      S_LOAD:    if (last_beat) state_d = S_LAYER_1;
      S_LAYER_1: if (layer_1_done_i) state_d = S_LAYER_2;
                 else if (timeout) state_d = S_ERROR;
      S_LAYER_2: if (layer_2_done_i) state_d = S_LAYER_3;
                 else if (timeout) state_d = S_ERROR;
      S_LAYER_3: if (layer_3_done_i) state_d = S_DONE;
                 else if (timeout) state_d = S_ERROR;
      S_DONE:    if (result_valid_q && result_ready_i) state_d = S_IDLE;
      S_ERROR:   if (start_i) state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pixel_index_d  = pixel_index_q;
    answer_d       = answer_q;
    clear_n_d      = !(state_d == S_LOAD && state_q != S_LOAD);
    result_valid_d = (state_d == S_DONE);
`ifdef BNN_SEQ_WATCHDOG_EN
    error_d        = (state_d == S_ERROR);
`else
    error_d        = 1'b0;
`endif
    if (state_q == S_LOAD) begin
      if (last_beat)          pixel_index_d = 10'd0;
      else if (pixel_valid_i) pixel_index_d = pixel_index_q + 10'd1;
    end else if (state_d == S_LOAD) begin
      pixel_index_d = 10'd0;
    end
    if (state_q == S_LAYER_3 && layer_3_done_i) answer_d = answer_in_i;
  end

  assign state_o         = state_q;
  assign pixel_ready_o   = (state_q == S_LOAD);
  assign pixel_we_o      = pixel_valid_i && pixel_ready_o;
  assign pixel_index_o   = pixel_index_q;
  assign layer_clear_n_o = clear_n_q;
  assign answer_o        = answer_q;
  assign result_valid_o  = result_valid_q;
  assign busy_o          = (state_q != S_IDLE);
  assign error_o         = error_q;

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// Directed bench for bnn_inference_sequencer; watchdog scenarios run when BNN_SEQ_WATCHDOG_EN is defined.
module tb_bnn_inference_sequencer;
  localparam int NP = 784;
`ifdef BNN_SEQ_WATCHDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, pixel_valid = 1'b0, pixel_in = 1'b0;
  logic       pixel_ready, pixel_we, layer_clear_n, result_valid, busy, error;
  logic [9:0] pixel_index;
  logic [2:0] state;
  logic       layer_1_done = 1'b0, layer_2_done = 1'b0, layer_3_done = 1'b0;
  logic [3:0] answer_in = 4'd0, answer;
  logic       result_ready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  bnn_inference_sequencer #(.NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .start_i(start),
    .pixel_valid_i(pixel_valid), .pixel_in_i(pixel_in),
    .pixel_ready_o(pixel_ready), .pixel_index_o(pixel_index), .pixel_we_o(pixel_we),
    .layer_clear_n_o(layer_clear_n), .state_o(state),
    .layer_1_done_i(layer_1_done), .layer_2_done_i(layer_2_done), .layer_3_done_i(layer_3_done),
    .answer_in_i(answer_in), .answer_o(answer), .result_valid_o(result_valid),
    .result_ready_i(result_ready), .busy_o(busy), .error_o(error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Start from IDLE/ERROR; the layers see the clear pulse and drop their sticky flags.
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    layer_1_done = 1'b0; layer_2_done = 1'b0; layer_3_done = 1'b0;
  endtask

  task automatic load_all;
    pixel_valid = 1'b1;
    for (int i = 0; i < NP; i++) begin
      pixel_in = 1'($urandom_range(1));
      tick;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset;
    compared++; if (state !== 3'b000)     begin mismatched++; $display("FAIL reset_state got %b exp 000", state); end
    compared++; if (pixel_index !== 10'd0) begin mismatched++; $display("FAIL reset_index got %0d exp 0", pixel_index); end
    compared++; if (layer_clear_n !== 1'b1) begin mismatched++; $display("FAIL reset_clear_n got %b exp 1", layer_clear_n); end
    compared++; if (answer !== 4'd0)       begin mismatched++; $display("FAIL reset_answer got %0d exp 0", answer); end
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rv got %b exp 0", result_valid); end
    compared++; if (busy !== 1'b0 || error !== 1'b0 || pixel_ready !== 1'b0)
      begin mismatched++; $display("FAIL reset_flags got busy=%b err=%b rdy=%b exp 0 0 0", busy, error, pixel_ready); end
  endtask

  task automatic test_full_run;
    do_start;
    compared++; if (state !== 3'b001)       begin mismatched++; $display("FAIL full_load_entry got %b exp 001", state); end
    compared++; if (layer_clear_n !== 1'b0) begin mismatched++; $display("FAIL full_clear_low got %b exp 0", layer_clear_n); end
    compared++; if (pixel_ready !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("FAIL full_ready got rdy=%b busy=%b exp 1 1", pixel_ready, busy); end
    pixel_valid = 1'b1;
    #1;
    compared++; if (pixel_we !== 1'b1) begin mismatched++; $display("FAIL full_we got %b exp 1", pixel_we); end
    tick;
    compared++; if (layer_clear_n !== 1'b1) begin mismatched++; $display("FAIL full_clear_high got %b exp 1", layer_clear_n); end
    compared++; if (pixel_index !== 10'd1)  begin mismatched++; $display("FAIL full_index1 got %0d exp 1", pixel_index); end
    for (int i = 1; i < NP; i++) begin
      if (i == NP - 1) begin
        compared++; if (pixel_index !== 10'd783 || state !== 3'b001)
          begin mismatched++; $display("FAIL full_last_beat got idx=%0d st=%b exp 783 001", pixel_index, state); end
      end
      tick;
    end
    pixel_valid = 1'b0;
    compared++; if (state !== 3'b010 || pixel_index !== 10'd0)
      begin mismatched++; $display("FAIL full_l1_entry got st=%b idx=%0d exp 010 0", state, pixel_index); end
    repeat (10) tick;
    compared++; if (state !== 3'b010) begin mismatched++; $display("FAIL full_l1_hold got %b exp 010", state); end
    layer_1_done = 1'b1; tick;
    compared++; if (state !== 3'b011) begin mismatched++; $display("FAIL full_l2_entry got %b exp 011", state); end
    repeat (20) tick;
    layer_2_done = 1'b1; tick;
    compared++; if (state !== 3'b100) begin mismatched++; $display("FAIL full_l3_entry got %b exp 100", state); end
    repeat (1960) tick;
    compared++; if (state !== 3'b100 || result_valid !== 1'b0)
      begin mismatched++; $display("FAIL full_l3_hold got st=%b rv=%b exp 100 0", state, result_valid); end
    answer_in = 4'd7; layer_3_done = 1'b1; tick;
    compared++; if (state !== 3'b101 || answer !== 4'd7 || result_valid !== 1'b1 || error !== 1'b0)
      begin mismatched++; $display("FAIL full_done got st=%b ans=%0d rv=%b err=%b exp 101 7 1 0", state, answer, result_valid, error); end
    answer_in = 4'hA;
    for (int i = 0; i < 5; i++) begin
      tick;
      compared++; if (state !== 3'b101 || answer !== 4'd7 || result_valid !== 1'b1)
        begin mismatched++; $display("FAIL backpressure_%0d got st=%b ans=%0d rv=%b exp 101 7 1", i, state, answer, result_valid); end
    end
    result_ready = 1'b1; tick; result_ready = 1'b0;
    compared++; if (state !== 3'b000 || result_valid !== 1'b0 || busy !== 1'b0 || answer !== 4'd7)
      begin mismatched++; $display("FAIL full_release got st=%b rv=%b busy=%b ans=%0d exp 000 0 0 7", state, result_valid, busy, answer); end
  endtask

  task automatic test_gapped_load;
    do_start;
    for (int k = 0; k < NP; k++) begin
      pixel_valid = 1'b1; tick;
      if (k == NP - 1) begin
        compared++; if (state !== 3'b010 || pixel_index !== 10'd0)
          begin mismatched++; $display("FAIL gap_l1_entry got st=%b idx=%0d exp 010 0", state, pixel_index); end
      end else begin
        compared++; if (pixel_index !== 10'(k + 1) || state !== 3'b001)
          begin mismatched++; $display("FAIL gap_valid_%0d got idx=%0d st=%b exp %0d 001", k, pixel_index, state, k + 1); end
        pixel_valid = 1'b0; tick;
        compared++; if (pixel_index !== 10'(k + 1))
          begin mismatched++; $display("FAIL gap_hold_%0d got %0d exp %0d", k, pixel_index, k + 1); end
      end
    end
    pixel_valid = 1'b0;
    result_ready = 1'b1;
    layer_1_done = 1'b1; tick;
    layer_2_done = 1'b1; tick;
    answer_in = 4'd3; layer_3_done = 1'b1; tick;
    compared++; if (state !== 3'b101 || result_valid !== 1'b1 || answer !== 4'd3)
      begin mismatched++; $display("FAIL ready_early_done got st=%b rv=%b ans=%0d exp 101 1 3", state, result_valid, answer); end
    tick;
    compared++; if (state !== 3'b000 || result_valid !== 1'b0)
      begin mismatched++; $display("FAIL ready_early_idle got st=%b rv=%b exp 000 0", state, result_valid); end
    result_ready = 1'b0;
  endtask

  task automatic test_ignored;
    do_start;
    load_all;
    start = 1'b1; layer_3_done = 1'b1; layer_2_done = 1'b1;
    repeat (3) tick;
    compared++; if (state !== 3'b010 || layer_clear_n !== 1'b1)
      begin mismatched++; $display("FAIL ignore_l1 got st=%b clr=%b exp 010 1", state, layer_clear_n); end
    start = 1'b0; layer_3_done = 1'b0; layer_2_done = 1'b0;
    layer_1_done = 1'b1; tick;
    layer_2_done = 1'b1; tick;
    answer_in = 4'd5; layer_3_done = 1'b1; tick;
    start = 1'b1; tick; start = 1'b0;
    compared++; if (state !== 3'b101 || answer !== 4'd5 || layer_clear_n !== 1'b1)
      begin mismatched++; $display("FAIL ignore_done got st=%b ans=%0d clr=%b exp 101 5 1", state, answer, layer_clear_n); end
    result_ready = 1'b1; tick; result_ready = 1'b0;
    compared++; if (state !== 3'b000) begin mismatched++; $display("FAIL ignore_idle got %b exp 000", state); end
  endtask

  task automatic test_reset_mid;
    do_start;
    load_all;
    layer_1_done = 1'b1; tick;
    repeat (3) tick;
    compared++; if (state !== 3'b011) begin mismatched++; $display("FAIL rstmid_pre got %b exp 011", state); end
    reset_n = 1'b0;
    #1;
    compared++; if (state !== 3'b000 || result_valid !== 1'b0 || answer !== 4'd0 || pixel_index !== 10'd0 || layer_clear_n !== 1'b1)
      begin mismatched++; $display("FAIL rstmid got st=%b rv=%b ans=%0d idx=%0d clr=%b exp 000 0 0 0 1", state, result_valid, answer, pixel_index, layer_clear_n); end
    layer_1_done = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    compared++; if (state !== 3'b000 || busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_release got st=%b busy=%b exp 000 0", state, busy); end
  endtask

`ifdef BNN_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    do_start;
    load_all;
    layer_1_done = 1'b1; tick;
    repeat (15) tick;
    compared++; if (state !== 3'b011 || error !== 1'b0)
      begin mismatched++; $display("FAIL wdog_pre got st=%b err=%b exp 011 0", state, error); end
    tick;
    compared++; if (state !== 3'b111 || error !== 1'b1 || busy !== 1'b1)
      begin mismatched++; $display("FAIL wdog_fire got st=%b err=%b busy=%b exp 111 1 1", state, error, busy); end
    repeat (3) tick;
    compared++; if (state !== 3'b111) begin mismatched++; $display("FAIL wdog_hold got %b exp 111", state); end
    do_start;
    compared++; if (state !== 3'b001 || error !== 1'b0 || layer_clear_n !== 1'b0)
      begin mismatched++; $display("FAIL wdog_restart got st=%b err=%b clr=%b exp 001 0 0", state, error, layer_clear_n); end
    load_all;
    layer_1_done = 1'b1; tick;
    repeat (15) tick;
    layer_2_done = 1'b1; tick;
    compared++; if (state !== 3'b100 || error !== 1'b0)
      begin mismatched++; $display("FAIL wdog_done_wins got st=%b err=%b exp 100 0", state, error); end
    answer_in = 4'd9; layer_3_done = 1'b1; result_ready = 1'b1; tick; tick;
    result_ready = 1'b0;
    compared++; if (state !== 3'b000 || answer !== 4'd9)
      begin mismatched++; $display("FAIL wdog_finish got st=%b ans=%0d exp 000 9", state, answer); end
  endtask
`endif

  initial begin
    repeat (2) tick;
    test_reset;
    reset_n = 1'b1;
    tick;
    test_full_run;
    test_gapped_load;
    test_ignored;
    test_reset_mid;
`ifdef BNN_SEQ_WATCHDOG_EN
    test_watchdog;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
